mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Upstream master for RAM_controller. Sequences every CPU memory transaction: instruction fetch at the PC, data load, and data store.
- Drives mem_cmd / mem_addr / write_data and captures the tri-stated read_data bus.
- Owns the program counter and the instruction register.
- Sits between the CPU control FSM and the RAM controller.

Parameters:
- RESET_PC, 9'd0, PC value loaded on reset.
- AW, 9, address width; bit AW-1 set = outside RAM.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- fetch_req  in  1  request instruction fetch at PC.
- ld_req  in  1  request data load from addr_in.
- st_req  in  1  request data store of st_data to addr_in.
- pc_load  in  1  load PC from pc_in (branch).
- addr_in  in  AW  data address for load/store.
- pc_in  in  AW  branch target.
- st_data  in  16  store data.
- mem_cmd  out  2  to RAM: MNONE 2'b00, MREAD 2'b01, MWRITE 2'b10.
- mem_addr  out  AW  to RAM.
- write_data  out  16  to RAM.
- read_data  in  16  from RAM (may be z).
- pc  out  AW  current program counter.
- ir  out  16  instruction register.
- ld_data  out  16  last loaded data word.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- fault  out  1  access fault pulse (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (async, reset_n=0): state=IDLE, pc=RESET_PC, ir=16'h0000, ld_data=16'h0000, mem_cmd=MNONE, write_data=16'h0000, busy=0, done=0, fault=0.
- States: IDLE, IF1, IF2, LD1, LD2, ST, DONE. Moore outputs.
- IDLE outputs: mem_cmd=MNONE, mem_addr=pc, write_data=0.
- IDLE transitions: requests are sampled only in IDLE. Priority is pc_load > st_req > ld_req > fetch_req.
  - pc_load: pc<=pc_in, go to DONE.
  - st_req: latch addr_in and st_data, go to ST.
  - ld_req: latch addr_in, go to LD1.
  - fetch_req: go to IF1.
  - No request: stay in IDLE.
- Requests arriving while busy are ignored. The requester holds its req until it sees done.
- IF1 and IF2: mem_cmd=MREAD, mem_addr=pc, both cycles. At the clock edge leaving IF2: ir<=read_data, pc<=pc+1, go to DONE.
- LD1 and LD2: mem_cmd=MREAD, mem_addr=latched address. At the edge leaving LD2: ld_data<=read_data, go to DONE.
- ST: mem_cmd=MWRITE, mem_addr=latched address, write_data=latched st_data, one cycle. The RAM writes on the edge leaving ST. Go to DONE.
- DONE: done=1, mem_cmd=MNONE. Unconditionally return to IDLE.
- Latency from request-sampling edge to done high: fetch 3 cycles, load 3, store 2, pc_load 1.
- PC increment is modulo 2^AW (511+1 -> 0). A PC with bit 8 set is still issued to RAM; the read returns z, which is captured as-is.
- Latched address and data are held stable for the whole transaction, even if addr_in or st_data change mid-transaction.
- Reset asserted mid-transaction: immediately returns to reset values. mem_cmd=MNONE in the same cycle, so no partial write is issued after reset asserts.

Optional Feature:
- Macro ADDR_FAULT_EN.
- Defined: in IDLE, a store or load whose addr_in[AW-1]=1, or a fetch whose pc[AW-1]=1, issues no memory command.
  - Goes directly to DONE with fault=1 for that single DONE cycle.
  - ir, ld_data and pc are unchanged.
- Undefined: no check is made, fault is tied 0, and the access proceeds as normal.

Test Plan:
1. Reset with RESET_PC=0, RAM word 0 = 16'hFFFF; pulse fetch_req -> mem_cmd=01 with mem_addr=0 for 2 cycles; ir=16'hFFFF; pc=1; done high exactly 3 cycles after the sampling edge.
2. st_req with addr_in=1, st_data=16'h0F0F, then ld_req with addr_in=1 -> exactly one cycle of mem_cmd=10 with write_data=16'h0F0F; ld_data=16'h0F0F; done pulses after 2 and 3 cycles respectively.
3. fetch_req, st_req and pc_load (pc_in=9'h0FF) asserted together in IDLE -> pc=9'h0FF, no memory command issued; the next fetch reads address 0xFF (16'hAAAA) into ir.
4. pc_load pc_in=9'h1FF, then fetch -> pc wraps to 0 after the fetch. With ADDR_FAULT_EN defined instead: fault=1, mem_cmd stays 00, pc stays 9'h1FF.
5. Assert reset_n=0 during ST -> mem_cmd drops to 00 without waiting for a clock edge; RAM word unchanged; pc=RESET_PC, ir=0, busy=0.
6. Change addr_in and st_data during LD1 and LD2 -> mem_addr stays at the originally latched value; requests raised while busy are ignored until IDLE is reached.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory access sequencer: instruction fetch, data load and data store towards the RAM controller.
// Owns the PC and IR. Optional macro ADDR_FAULT_EN blocks accesses whose address has bit AW-1 set.
module mem_access_unit #(
    parameter int            AW       = 9,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          fetch_req,
    input  logic          ld_req,
    input  logic          st_req,
    input  logic          pc_load,
    input  logic [AW-1:0] addr_in,
    input  logic [AW-1:0] pc_in,
    input  logic [15:0]   st_data,
    output logic [1:0]    mem_cmd,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   write_data,
    input  logic [15:0]   read_data,
    output logic [AW-1:0] pc,
    output logic [15:0]   ir,
    output logic [15:0]   ld_data,
    output logic          busy,
    output logic          done,
    output logic          fault
);

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_IF1  = 3'd1;
    localparam logic [2:0] S_IF2  = 3'd2;
    localparam logic [2:0] S_LD1  = 3'd3;
    localparam logic [2:0] S_LD2  = 3'd4;
    localparam logic [2:0] S_ST   = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [15:0]   ir_q, ir_d;
    logic [15:0]   ld_data_q, ld_data_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          fault_q, fault_d;

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        ld_data_d = ld_data_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        fault_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pc_load) begin
                    pc_d    = pc_in;
                    state_d = S_DONE;
                end else if (st_req) begin
`ifdef ADDR_FAULT_EN
                    if (addr_in[AW-1]) begin
                        fault_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_in;
                        wdata_d = st_data;
                        state_d = S_ST;
                    end
`else
                    addr_d  = addr_in;
                    wdata_d = st_data;
                    state_d = S_ST;
`endif
                end else if (ld_req) begin
`ifdef ADDR_FAULT_EN
                    if (addr_in[AW-1]) begin
                        fault_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_in;
                        state_d = S_LD1;
                    end
`else
                    addr_d  = addr_in;
                    state_d = S_LD1;
`endif
                end else if (fetch_req) begin
`ifdef ADDR_FAULT_EN
                    if (pc_q[AW-1]) begin
                        fault_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_IF1;
                    end
`else
                    state_d = S_IF1;
`endif
                end
            end
            S_IF1: state_d = S_IF2;
            S_IF2: begin
                ir_d    = read_data;
                pc_d    = pc_q + AW'(1);
                state_d = S_DONE;
            end
            S_LD1: state_d = S_LD2;
            S_LD2: begin
                ld_data_d = read_data;
                state_d   = S_DONE;
            end
            S_ST:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= 16'h0000;
            ld_data_q <= 16'h0000;
            addr_q    <= '0;
            wdata_q   <= 16'h0000;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            ld_data_q <= ld_data_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            fault_q   <= fault_d;
        end
    end

    // Outputs decode from state alone, so an async reset drops mem_cmd without waiting for an edge.
    always_comb begin
        mem_cmd    = MNONE;
        mem_addr   = pc_q;
        write_data = 16'h0000;
        case (state_q)
            S_IF1, S_IF2: mem_cmd = MREAD;
            S_LD1, S_LD2: begin
                mem_cmd  = MREAD;
                mem_addr = addr_q;
            end
            S_ST: begin
                mem_cmd    = MWRITE;
                mem_addr   = addr_q;
                write_data = wdata_q;
            end
            default: mem_cmd = MNONE;
        endcase
    end

    assign pc      = pc_q;
    assign ir      = ir_q;
    assign ld_data = ld_data_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);

`ifdef ADDR_FAULT_EN
    assign fault = fault_q;
`else
    logic unused_fault;
    assign unused_fault = fault_q;
    assign fault        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus queues expected completions, a negedge monitor checks them.
module tb_mem_access_unit;

    logic        clk;
    logic        reset_n;
    logic        fetch_req, ld_req, st_req, pc_load;
    logic [8:0]  addr_in, pc_in;
    logic [15:0] st_data;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    wire  [15:0] read_data;
    logic [8:0]  pc;
    logic [15:0] ir, ld_data;
    logic        busy, done, fault;

    mem_access_unit #(.AW(9), .RESET_PC(9'd0)) dut (
        .clk(clk), .reset_n(reset_n),
        .fetch_req(fetch_req), .ld_req(ld_req), .st_req(st_req), .pc_load(pc_load),
        .addr_in(addr_in), .pc_in(pc_in), .st_data(st_data),
        .mem_cmd(mem_cmd), .mem_addr(mem_addr), .write_data(write_data), .read_data(read_data),
        .pc(pc), .ir(ir), .ld_data(ld_data), .busy(busy), .done(done), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: 256 words, addresses with bit 8 set are outside RAM and float the bus.
    logic [15:0] ram [0:255];
    assign read_data = (mem_cmd == 2'b01 && !mem_addr[8]) ? ram[mem_addr[7:0]] : 16'hzzzz;
    always @(posedge clk)
        if (mem_cmd == 2'b10 && !mem_addr[8]) ram[mem_addr[7:0]] <= write_data;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        int          done_cyc;
        logic [8:0]  pc;
        logic [15:0] ir;
        logic        chk_ir;
        logic [15:0] ld;
        logic        fault;
        int          nrd;
        int          nwr;
        logic [8:0]  addr;
        logic [15:0] wdata;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: tracks bus activity per transaction and checks the front entry on every done pulse.
    int n_rd = 0, n_wr = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            n_rd = 0;
            n_wr = 0;
        end else begin
            if (mem_cmd == 2'b01) n_rd++;
            if (mem_cmd == 2'b10) n_wr++;
            if (mem_cmd != 2'b00) begin
                if (q.size() == 0) check("cmd_without_txn", {30'd0, mem_cmd}, 32'd0);
                else begin
                    check({q[0].name, "_addr"}, {23'd0, mem_addr}, {23'd0, q[0].addr});
                    if (mem_cmd == 2'b10)
                        check({q[0].name, "_wdata"}, {16'd0, write_data}, {16'd0, q[0].wdata});
                end
            end
            if (done) begin
                if (q.size() == 0) check("spurious_done", 32'd1, 32'd0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    check({e.name, "_latency"}, cyc, e.done_cyc);
                    check({e.name, "_pc"}, {23'd0, pc}, {23'd0, e.pc});
                    if (e.chk_ir) check({e.name, "_ir"}, {16'd0, ir}, {16'd0, e.ir});
                    check({e.name, "_ld"}, {16'd0, ld_data}, {16'd0, e.ld});
                    check({e.name, "_fault"}, {31'd0, fault}, {31'd0, e.fault});
                    check({e.name, "_nread"}, n_rd, e.nrd);
                    check({e.name, "_nwrite"}, n_wr, e.nwr);
                end
                n_rd = 0;
                n_wr = 0;
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            if (!busy) return;
            @(negedge clk); #1;
        end
        check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            if (q.size() == 0) return;
            @(negedge clk); #1;
        end
        check("done_timeout", q.size(), 32'd0);
        q.delete();
    endtask

    // Drives one request for a single sampling edge and queues its expected completion.
    task automatic start_txn(input string nm, input logic fr, input logic lr, input logic sr,
                             input logic pl, input logic [8:0] a, input logic [8:0] pi,
                             input logic [15:0] sd, input int lat, input logic [8:0] e_pc,
                             input logic [15:0] e_ir, input logic e_chk_ir, input logic [15:0] e_ld,
                             input logic e_fault, input int e_rd, input int e_wr,
                             input logic [8:0] e_addr, input logic [15:0] e_wd);
        exp_t e;
        wait_idle();
        fetch_req = fr; ld_req = lr; st_req = sr; pc_load = pl;
        addr_in = a; pc_in = pi; st_data = sd;
        e.name = nm; e.done_cyc = cyc + lat; e.pc = e_pc; e.ir = e_ir; e.chk_ir = e_chk_ir;
        e.ld = e_ld; e.fault = e_fault; e.nrd = e_rd; e.nwr = e_wr; e.addr = e_addr; e.wdata = e_wd;
        q.push_back(e);
        @(negedge clk); #1;
        fetch_req = 0; ld_req = 0; st_req = 0; pc_load = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'h1000 + 16'(i);
        ram[0]     = 16'hFFFF;
        ram[8'hFF] = 16'hAAAA;
        reset_n = 0; fetch_req = 0; ld_req = 0; st_req = 0; pc_load = 0;
        addr_in = 0; pc_in = 0; st_data = 0;
        repeat (2) @(negedge clk);
        check("rst_pc", {23'd0, pc}, 32'd0);
        check("rst_ir", {16'd0, ir}, 32'd0);
        check("rst_ld", {16'd0, ld_data}, 32'd0);
        check("rst_cmd", {30'd0, mem_cmd}, 32'd0);
        check("rst_wdata", {16'd0, write_data}, 32'd0);
        check("rst_busy_done_fault", {29'd0, busy, done, fault}, 32'd0);
        #1 reset_n = 1;
        @(negedge clk); #1;

        // Fetch at PC 0, store then load at address 1.
        start_txn("fetch0", 1,0,0,0, 9'h000, 9'h000, 16'h0000, 3, 9'h001, 16'hFFFF, 1, 16'h0000, 0, 2, 0, 9'h000, 16'h0);
        wait_done();
        start_txn("store1", 0,0,1,0, 9'h001, 9'h000, 16'h0F0F, 2, 9'h001, 16'hFFFF, 1, 16'h0000, 0, 0, 1, 9'h001, 16'h0F0F);
        wait_done();
        start_txn("load1",  0,1,0,0, 9'h001, 9'h000, 16'h0000, 3, 9'h001, 16'hFFFF, 1, 16'h0F0F, 0, 2, 0, 9'h001, 16'h0);
        wait_done();

        // Simultaneous requests: pc_load wins, nothing reaches the bus.
        start_txn("prio",   1,0,1,1, 9'h005, 9'h0FF, 16'h1234, 1, 9'h0FF, 16'hFFFF, 1, 16'h0F0F, 0, 0, 0, 9'h000, 16'h0);
        wait_done();
        start_txn("fetchFF",1,0,0,0, 9'h000, 9'h000, 16'h0000, 3, 9'h100, 16'hAAAA, 1, 16'h0F0F, 0, 2, 0, 9'h0FF, 16'h0);
        wait_done();
        check("prio_ram5", {16'd0, ram[5]}, 32'h1005);

        // PC at the top of the address space.
        start_txn("pc1FF",  0,0,0,1, 9'h000, 9'h1FF, 16'h0000, 1, 9'h1FF, 16'hAAAA, 1, 16'h0F0F, 0, 0, 0, 9'h000, 16'h0);
        wait_done();
`ifdef ADDR_FAULT_EN
        start_txn("fetch1FF",1,0,0,0, 9'h000, 9'h000, 16'h0000, 1, 9'h1FF, 16'hAAAA, 1, 16'h0F0F, 1, 0, 0, 9'h000, 16'h0);
        wait_done();
        start_txn("st105",  0,0,1,0, 9'h105, 9'h000, 16'hBEEF, 1, 9'h1FF, 16'hAAAA, 1, 16'h0F0F, 1, 0, 0, 9'h000, 16'h0);
        wait_done();
`else
        start_txn("fetch1FF",1,0,0,0, 9'h000, 9'h000, 16'h0000, 3, 9'h000, 16'h0000, 0, 16'h0F0F, 0, 2, 0, 9'h1FF, 16'h0);
        wait_done();
        start_txn("st105",  0,0,1,0, 9'h105, 9'h000, 16'hBEEF, 2, 9'h000, 16'h0000, 0, 16'h0F0F, 0, 0, 1, 9'h105, 16'hBEEF);
        wait_done();
`endif
        check("st105_ram5", {16'd0, ram[5]}, 32'h1005);

        // Reset asserted while the store is on the bus.
        start_txn("pc2",    0,0,0,1, 9'h000, 9'h002, 16'h0000, 1, 9'h002, 16'h0000, 0, 16'h0F0F, 0, 0, 0, 9'h000, 16'h0);
        wait_done();
        start_txn("st3rst", 0,0,1,0, 9'h003, 9'h000, 16'h5555, 2, 9'h002, 16'h0000, 0, 16'h0F0F, 0, 0, 1, 9'h003, 16'h5555);
        check("st_cmd_before_rst", {30'd0, mem_cmd}, 32'd2);
        #2 reset_n = 0;
        #1;
        check("rst_mid_cmd", {30'd0, mem_cmd}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_pc", {23'd0, pc}, 32'd0);
        check("rst_mid_ir", {16'd0, ir}, 32'd0);
        check("rst_mid_ld", {16'd0, ld_data}, 32'd0);
        q.delete();
        @(negedge clk); #1;
        reset_n = 1;
        check("rst_mid_ram3", {16'd0, ram[3]}, 32'h1003);
        @(negedge clk); #1;

        // Inputs churn and other requests arrive during a load; all are ignored.
        start_txn("ld7",    0,1,0,0, 9'h007, 9'h000, 16'h0000, 3, 9'h000, 16'h0000, 1, 16'h1007, 0, 2, 0, 9'h007, 16'h0);
        addr_in = 9'h009; st_data = 16'h9999; st_req = 1; fetch_req = 1; pc_load = 1; pc_in = 9'h055;
        @(negedge clk); #1;
        addr_in = 9'h00B;
        @(negedge clk); #1;
        st_req = 0; fetch_req = 0; pc_load = 0;
        wait_done();
        repeat (3) @(negedge clk);
        check("ignored_busy", {31'd0, busy}, 32'd0);
        check("ignored_pc", {23'd0, pc}, 32'd0);
        check("ignored_ram9", {16'd0, ram[9]}, 32'h1009);
        #1;
        start_txn("fetch_after", 1,0,0,0, 9'h000, 9'h000, 16'h0000, 3, 9'h001, 16'hFFFF, 1, 16'h1007, 0, 2, 0, 9'h000, 16'h0);
        wait_done();
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
